viterbi_ctrl: RTL

Frame sequencer for the K=3, rate-1/2 Viterbi decoder datapath. It accepts 2-bit encoded symbols under valid/ready and steps the add-compare-select (ACS) unit once per symbol, with survivor-memory write addressing. At frame end it runs a one-step-per-cycle traceback over the survivor memory and returns the decoded bits in order under valid/ready. The ACS arithmetic and the survivor storage stay in the datapath; this block owns sequencing, addressing, traceback state and output buffering.

---
 rtl/viterbi_pkg.sv | 24 ++
 rtl/viterbi_ctrl_if.sv | 36 +++
 rtl/viterbi_out_buf.sv | 76 +++++++
 rtl/viterbi_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, FSM state type and trellis helper for the K=3, rate-1/2
// Viterbi frame controller.
package viterbi_pkg;

  localparam int unsigned K          = 3;
  localparam int unsigned STATE_W    = K - 1;
  localparam int unsigned NUM_STATES = 2 ** STATE_W;
  localparam int unsigned TB_DEPTH   = 15;
  localparam int unsigned ADDR_W     = $clog2(TB_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StTb,
    StOut
  } state_e;

  // State s = {u_t, u_(t-1)}; its predecessor is {u_(t-1), decision bit of s}.
  function automatic logic [STATE_W-1:0] prev_state(input logic [STATE_W-1:0]    state,
                                                    input logic [NUM_STATES-1:0] decision);
    return {state[STATE_W-2:0], decision[state]};
  endfunction

endpackage

// File: rtl/viterbi_ctrl_if.sv
// Signal bundle between the Viterbi frame controller and its surroundings
// (symbol source, ACS/survivor datapath, decoded-bit sink).
//   master : controller view (drives ready, ACS strobes, survivor reads, decoded bits, errors)
//   slave  : environment view (drives symbols, survivor decisions, sink ready)
interface viterbi_ctrl_if;
  import viterbi_pkg::*;

  logic                  sym_valid;
  logic                  sym_ready;
  logic                  sym_last;
  logic                  acs_en;
  logic                  acs_first;
  logic [ADDR_W-1:0]     acs_addr;
  logic                  tb_rd_en;
  logic [ADDR_W-1:0]     tb_rd_addr;
  logic [NUM_STATES-1:0] tb_surv;
  logic                  dec_valid;
  logic                  dec_ready;
  logic                  dec_bit;
  logic                  dec_last;
  logic                  err_short;
  logic                  err_ovf;

  modport master (
    input  sym_valid, sym_last, tb_surv, dec_ready,
    output sym_ready, acs_en, acs_first, acs_addr, tb_rd_en, tb_rd_addr,
           dec_valid, dec_bit, dec_last, err_short, err_ovf
  );

  modport slave (
    output sym_valid, sym_last, tb_surv, dec_ready,
    input  sym_ready, acs_en, acs_first, acs_addr, tb_rd_en, tb_rd_addr,
           dec_valid, dec_bit, dec_last, err_short, err_ovf
  );

endinterface

// File: rtl/viterbi_out_buf.sv
// Decoded-bit buffer: TB_DEPTH bits written by index during traceback, read
// back in index order through a registered valid/ready port.
//   clk, rst_n        : clock, async active-low reset (read port only)
//   wr_en/wr_idx/wr_bit : write one decoded bit at an index
//   rd_active         : read port enabled; dropping it rewinds the read pointer
//   rd_last_idx       : index of the final bit of the frame
//   rd_valid/rd_ready/rd_bit/rd_last : in-order read handshake
module viterbi_out_buf
  import viterbi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic              wr_bit,
  input  logic              rd_active,
  input  logic [ADDR_W-1:0] rd_last_idx,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_bit,
  output logic              rd_last
);

  logic [TB_DEPTH-1:0] mem_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                valid_q, valid_d;
  logic                bit_q, bit_d;
  logic                last_q, last_d;
  logic                load;

  // Storage is not reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_bit;
  end

  // Load a new bit when the output slot is empty or being emptied, except
  // after the last bit (the controller leaves the output state on that beat).
  assign load = rd_active & (~valid_q | (rd_ready & ~last_q));

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    bit_d   = bit_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      bit_d   = mem_q[ptr_q];
      last_d  = (ptr_q == rd_last_idx);
      ptr_d   = ptr_q + ADDR_W'(1);
    end else if (valid_q && rd_ready) begin
      valid_d = 1'b0;
      bit_d   = 1'b0;
      last_d  = 1'b0;
    end
    if (!rd_active) ptr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_bit   = bit_q;
  assign rd_last  = last_q;

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the K=3 rate-1/2 Viterbi datapath. Accepts symbols,
// strobes the ACS unit with survivor write addresses, then walks the survivor
// memory backwards one address per cycle and streams out the decoded bits.
//   clk, rst_n : clock, async active-low reset
//   bus        : viterbi_ctrl_if.master (symbol in, ACS strobes, survivor
//                reads, decoded-bit out, error pulses); all outputs registered
module viterbi_ctrl
  import viterbi_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  viterbi_ctrl_if.master bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   n_q, n_d;
  logic                sym_ready_q, sym_ready_d;
  logic                acs_en_q, acs_en_d;
  logic                acs_first_q, acs_first_d;
  logic [ADDR_W-1:0]   acs_addr_q, acs_addr_d;
  logic                err_short_q, err_short_d;
  logic                err_ovf_q, err_ovf_d;
  logic                tb_rd_en_q, tb_rd_en_d;
  logic [ADDR_W-1:0]   tb_rd_addr_q, tb_rd_addr_d;
  logic                rd_vld_q;
  logic [ADDR_W-1:0]   rd_vld_addr_q;
  logic [STATE_W-1:0]  tb_state_q, tb_state_d;

  logic                sym_hs, frame_end;
  logic                buf_wr_en;
  logic [ADDR_W-1:0]   buf_wr_idx;
  logic                dec_valid, dec_bit, dec_last;

  assign sym_hs    = bus.sym_valid & sym_ready_q;
  assign frame_end = sym_hs & (bus.sym_last | (n_q == ADDR_W'(TB_DEPTH - 1)));

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    sym_ready_d  = sym_ready_q;
    acs_en_d     = 1'b0;
    acs_first_d  = 1'b0;
    acs_addr_d   = acs_addr_q;
    err_short_d  = 1'b0;
    err_ovf_d    = 1'b0;
    tb_rd_en_d   = 1'b0;
    tb_rd_addr_d = tb_rd_addr_q;
    unique case (state_q)
      StIdle, StRecv: begin
        sym_ready_d = 1'b1;
        if (sym_hs) begin
          n_d         = n_q + ADDR_W'(1);
          acs_en_d    = 1'b1;
          acs_first_d = (n_q == '0);
          acs_addr_d  = n_q;
          state_d     = StRecv;
          if (frame_end) begin
            sym_ready_d = 1'b0;
            // Without sym_last the frame can only have ended by hitting depth.
            err_ovf_d   = ~bus.sym_last;
            if (n_q < ADDR_W'(2)) begin
              err_short_d = 1'b1;
              n_d         = '0;
              state_d     = StIdle;
            end else begin
              state_d = StTb;
            end
          end
        end
      end
      StTb: begin
        // One idle cycle on entry, then addresses n-1 down to 0.
        if (!tb_rd_en_q) begin
          tb_rd_en_d   = 1'b1;
          tb_rd_addr_d = n_q - ADDR_W'(1);
        end else if (tb_rd_addr_q == '0) begin
          state_d = StOut;
        end else begin
          tb_rd_en_d   = 1'b1;
          tb_rd_addr_d = tb_rd_addr_q - ADDR_W'(1);
        end
      end
      StOut: begin
        if (dec_valid && bus.dec_ready && dec_last) begin
          state_d     = StIdle;
          n_d         = '0;
          sym_ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Traceback: decoded u_t = s_t[1] = s_(t+1)[0], so buffer[t] is written
  // while consuming the decisions from address t+1. This lands buffer[0]
  // before the output stage reads it; address 0's vector only moves the state.
  always_comb begin
    tb_state_d = tb_state_q;
    buf_wr_en  = 1'b0;
    buf_wr_idx = '0;
    if (state_q inside {StIdle, StRecv}) begin
      tb_state_d = '0;
    end else if (rd_vld_q) begin
      tb_state_d = prev_state(tb_state_q, bus.tb_surv);
      // Addresses n-1 would yield u_(n-2), a tail bit, so they are skipped.
      if (rd_vld_addr_q != '0 && rd_vld_addr_q <= n_q - ADDR_W'(2)) begin
        buf_wr_en  = 1'b1;
        buf_wr_idx = rd_vld_addr_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      n_q           <= '0;
      sym_ready_q   <= 1'b0;
      acs_en_q      <= 1'b0;
      acs_first_q   <= 1'b0;
      acs_addr_q    <= '0;
      err_short_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
      tb_rd_en_q    <= 1'b0;
      tb_rd_addr_q  <= '0;
      rd_vld_q      <= 1'b0;
      rd_vld_addr_q <= '0;
      tb_state_q    <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      sym_ready_q   <= sym_ready_d;
      acs_en_q      <= acs_en_d;
      acs_first_q   <= acs_first_d;
      acs_addr_q    <= acs_addr_d;
      err_short_q   <= err_short_d;
      err_ovf_q     <= err_ovf_d;
      tb_rd_en_q    <= tb_rd_en_d;
      tb_rd_addr_q  <= tb_rd_addr_d;
      rd_vld_q      <= tb_rd_en_q;
      rd_vld_addr_q <= tb_rd_addr_q;
      tb_state_q    <= tb_state_d;
    end
  end

  viterbi_out_buf u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (buf_wr_en),
    .wr_idx      (buf_wr_idx),
    .wr_bit      (tb_state_q[0]),
    .rd_active   (state_q == StOut),
    .rd_last_idx (n_q - ADDR_W'(3)),
    .rd_valid    (dec_valid),
    .rd_ready    (bus.dec_ready),
    .rd_bit      (dec_bit),
    .rd_last     (dec_last)
  );

  assign bus.sym_ready  = sym_ready_q;
  assign bus.acs_en     = acs_en_q;
  assign bus.acs_first  = acs_first_q;
  assign bus.acs_addr   = acs_addr_q;
  assign bus.tb_rd_en   = tb_rd_en_q;
  assign bus.tb_rd_addr = tb_rd_addr_q;
  assign bus.dec_valid  = dec_valid;
  assign bus.dec_bit    = dec_bit;
  assign bus.dec_last   = dec_last;
  assign bus.err_short  = err_short_q;
  assign bus.err_ovf    = err_ovf_q;

endmodule
